// File: rtl/fifo_rd_stream_adapter_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter_if
// Purpose : groups the two handshake sides of fifo_rd_stream_adapter.
//           FIFO side   : i_fifo_empty, o_fifo_rd_en, i_fifo_data
//           Stream side : o_valid, i_ready, o_data, o_last
// Modports:
//   slave  - the adapter's view (FIFO status/data and ready in, read/stream out)
//   master - the environment's view (FIFO model plus downstream sink)
// Signal names keep the adapter-relative i_/o_ prefixes so both views read
// the same way as the adapter's port list.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_adapter_if #(
  parameter int SIZE_DATA = 8
) ();
  logic                 i_fifo_empty;
  logic                 o_fifo_rd_en;
  logic [SIZE_DATA-1:0] i_fifo_data;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_data;
  logic                 o_last;

  modport slave (
    input  i_fifo_empty, i_fifo_data, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_last
  );

  modport master (
    output i_fifo_empty, i_fifo_data, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_last
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Purpose : drains a 1-cycle-latency FIFO read port into a valid/ready stream
//           through a 2-entry buffer, sustaining one word per cycle under
//           continuous ready. Marks every FRAME_LEN-th word with o_last and
//           counts completed frames.
// Ports   :
//   i_clk         - FIFO read clock
//   i_rst_n       - asynchronous active-low reset
//   i_flush       - synchronous flush of buffered / in-flight words and frame
//   bus (slave)   - FIFO side (empty, rd_en, data) and stream side
//                   (valid, ready, data, last)
//   o_frames_done - completed frame count, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
  parameter int SIZE_DATA = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  fifo_rd_stream_adapter_if.slave bus,
  output logic [15:0]             o_frames_done
);

  localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  logic [SIZE_DATA-1:0] buf_q [2];
  logic [SIZE_DATA-1:0] buf_d [2];
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [1:0]           occ_q, occ_d;
  logic                 pending_q, pending_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [15:0]          frames_q, frames_d;

  logic                 valid;
  logic                 pop;
  logic                 last;
  logic                 rd_en;
  logic [2:0]           level;

  // Handshake and read-issue logic. level is the number of words that will be
  // held or in flight after this edge, excluding a read issued now; a new read
  // is only allowed while that stays below the buffer depth, so the capture
  // slot is always free when the data returns. The ready->rd_en path is
  // deliberate: a pop this cycle frees a slot for a read this cycle.
  always_comb begin
    valid = (occ_q != 2'd0);
    pop   = valid & bus.i_ready;
    last  = valid & (fcnt_q == FCNT_LAST);
    level = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
    rd_en = i_rst_n & ~bus.i_fifo_empty & ~i_flush & (level < 3'd2);
  end

  always_comb begin
    buf_d     = buf_q;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    pending_d = rd_en;
    fcnt_d    = fcnt_q;
    frames_d  = frames_q;

    if (pop) begin
      head_d = ~head_q;
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d   = '0;
        frames_d = frames_q + 16'd1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Data from the read issued last cycle is present on i_fifo_data now.
    if (pending_q) begin
      buf_d[tail_q] = bus.i_fifo_data;
      tail_d        = ~tail_q;
    end

    occ_d = level[1:0];

    // Flush drops everything buffered or in flight, but a pop happening in the
    // same cycle still completes its frame (frames_d above is kept).
    if (i_flush) begin
      head_d    = 1'b0;
      tail_d    = 1'b0;
      occ_d     = 2'd0;
      pending_d = 1'b0;
      fcnt_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      occ_q     <= 2'd0;
      pending_q <= 1'b0;
      fcnt_q    <= '0;
      frames_q  <= 16'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      pending_q <= pending_d;
      fcnt_q    <= fcnt_d;
      frames_q  <= frames_d;
    end
  end

  // Buffer entries are cleared on reset so o_data reads 0 while idle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        buf_q[gi] <= '0;
      end else begin
        buf_q[gi] <= buf_d[gi];
      end
    end
  end

  assign bus.o_fifo_rd_en = rd_en;
  assign bus.o_valid      = valid;
  assign bus.o_data       = buf_q[head_q];
  assign bus.o_last       = last;
  assign o_frames_done    = frames_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
// Self-checking bench: a queue-based FIFO source feeds the adapter; every word
// the FIFO hands out is pushed to an expected-stream queue, and a negedge
// monitor pops and compares whenever the stream side transfers a word.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;

  localparam int SD = 8;
  localparam int FL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] frames_done;

  fifo_rd_stream_adapter_if #(.SIZE_DATA(SD)) bus ();

  fifo_rd_stream_adapter #(.SIZE_DATA(SD), .FRAME_LEN(FL)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .bus           (bus.slave),
    .o_frames_done (frames_done)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [SD-1:0] src[$];     // words still inside the FIFO
  logic [SD-1:0] expq[$];    // words read from the FIFO, not yet delivered
  int            pend_m;     // a read was accepted at the last edge
  int            widx;       // words delivered in the current frame
  int            exp_frames;
  logic          rd_acc;
  logic [SD-1:0] next_word;
  logic          force_empty;
  logic          prev_stall;
  logic [SD-1:0] prev_data;
  logic          prev_last;
  logic          pop_s;
  logic [SD-1:0] w;

  int n_chk = 0;
  int n_pass = 0;
  int pop_cnt = 0;
  int rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic upd_empty();
    bus.i_fifo_empty = force_empty || (src.size() == 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    upd_empty();
  endtask

  task automatic run_until(input int n, input int budget, input bit toggle);
    int start;
    int cyc;
    start = pop_cnt;
    cyc = 0;
    while ((pop_cnt - start) < n && cyc < budget) begin
      if (toggle) bus.i_ready = ~bus.i_ready;
      step();
      cyc++;
    end
    chk("pop_count", 32'(pop_cnt - start), 32'(n));
  endtask

  // FIFO output register: data of an accepted read appears after the edge.
  always @(posedge clk) begin
    if (rd_acc) bus.i_fifo_data <= next_word;
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_last", 32'(bus.o_last), 32'd0);
      chk("rst_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
      chk("rst_data", 32'(bus.o_data), 32'd0);
      chk("rst_frames", 32'(frames_done), 32'd0);
      expq.delete();
      pend_m = 0;
      widx = 0;
      exp_frames = 0;
      rd_acc = 1'b0;
      prev_stall = 1'b0;
    end else begin
      pop_s = bus.o_valid & bus.i_ready;
      chk("valid", 32'(bus.o_valid), 32'((expq.size() - pend_m) > 0));
      chk("rd_en", 32'(bus.o_fifo_rd_en),
          32'(!bus.i_fifo_empty && !flush && ((expq.size() - int'(pop_s)) < 2)));
      chk("frames", 32'(frames_done), 32'(exp_frames));
      if (prev_stall && bus.o_valid) begin
        chk("hold_data", 32'(bus.o_data), 32'(prev_data));
        chk("hold_last", 32'(bus.o_last), 32'(prev_last));
      end
      if (pop_s) begin
        chk("pop_has_word", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          w = expq.pop_front();
          chk("data", 32'(bus.o_data), 32'(w));
          chk("last", 32'(bus.o_last), 32'(widx == FL - 1));
          $display("pop data=%02h last=%0d frames=%0d", bus.o_data, bus.o_last, frames_done);
          widx = (widx + 1) % FL;
          if (widx == 0) exp_frames = (exp_frames + 1) & 32'hFFFF;
        end
        pop_cnt++;
      end
      rd_acc = bus.o_fifo_rd_en && !bus.i_fifo_empty;
      if (rd_acc) begin
        if (src.size() != 0) next_word = src.pop_front();
        expq.push_back(next_word);
        rd_cnt++;
      end
      if (flush) begin
        expq.delete();
        pend_m = 0;
        widx = 0;
      end else begin
        pend_m = int'(rd_acc);
      end
      prev_stall = bus.o_valid && !bus.i_ready && !flush;
      prev_data  = bus.o_data;
      prev_last  = bus.o_last;
    end
  end

  initial begin
    int r0;
    int f0;
    force_empty      = 1'b0;
    bus.i_ready      = 1'b0;
    bus.i_fifo_empty = 1'b0;
    bus.i_fifo_data  = '0;
    rd_acc           = 1'b0;
    next_word        = '0;

    // 1. Reset held with a non-empty FIFO indication.
    rst_n = 1'b0;
    repeat (4) step();
    bus.i_fifo_empty = 1'b0;
    #1;
    chk("t1_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    upd_empty();

    // 2. Streaming 0x01..0x10 with continuous ready.
    for (int i = 1; i <= 16; i++) src.push_back(SD'(i));
    upd_empty();
    bus.i_ready = 1'b1;
    run_until(16, 60, 1'b0);
    repeat (3) step();
    chk("t2_frames", 32'(frames_done), 32'd1);

    // 3. Backpressure then toggling ready.
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 16; i++) src.push_back(SD'(i));
    upd_empty();
    r0 = rd_cnt;
    repeat (10) step();
    chk("t3_reads", 32'(rd_cnt - r0), 32'd2);
    chk("t3_hold_data", 32'(bus.o_data), 32'h01);
    chk("t3_hold_valid", 32'(bus.o_valid), 32'd1);
    run_until(16, 100, 1'b1);
    repeat (3) step();
    chk("t3_frames", 32'(frames_done), 32'd2);

    // 4. Empty FIFO with ready high.
    force_empty = 1'b1;
    bus.i_ready = 1'b1;
    upd_empty();
    repeat (50) step();
    chk("t4_valid", 32'(bus.o_valid), 32'd0);
    force_empty = 1'b0;
    upd_empty();

    // 5. Flush mid-frame with a read in flight.
    for (int i = 0; i < 40; i++) src.push_back(SD'(8'h40 + i));
    upd_empty();
    run_until(5, 30, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_valid_after_flush", 32'(bus.o_valid), 32'd0);
    f0 = int'(frames_done);
    run_until(16, 60, 1'b0);
    chk("t5_frames", 32'(frames_done), 32'(f0 + 1));
    bus.i_ready = 1'b0;
    flush = 1'b1;
    src.delete();
    step();
    flush = 1'b0;
    upd_empty();

    // 6. Asynchronous reset mid-transfer, then fresh data.
    for (int i = 0; i < 16; i++) src.push_back(SD'(i));
    upd_empty();
    bus.i_ready = 1'b1;
    run_until(7, 40, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.o_valid), 32'd0);
    chk("t6_async_data", 32'(bus.o_data), 32'd0);
    chk("t6_async_frames", 32'(frames_done), 32'd0);
    chk("t6_async_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
    src.delete();
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) src.push_back(SD'(8'h20 + i));
    upd_empty();
    run_until(16, 60, 1'b0);
    repeat (2) step();
    chk("t6_frames", 32'(frames_done), 32'd1);

    // Randomized traffic: ready, flush, empty and bursts all vary.
    for (int c = 0; c < 600; c++) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      force_empty = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        int nb;
        nb = int'($urandom_range(1, 4));
        for (int k = 0; k < nb; k++) src.push_back(SD'($urandom));
      end
      upd_empty();
      step();
    end
    flush = 1'b0;
    force_empty = 1'b0;
    bus.i_ready = 1'b1;
    repeat (200) step();
    chk("drain_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
